// File: rtl/dds_prog_arb.sv
// Round-robin arbiter between the pulse sequencer and host scan engine for the DDS programming path.
// Each grant loads the 32-bit word as two halves, strobes state_start, waits out the serial transfer, then acks.
module dds_prog_arb #(
    parameter int unsigned XFER_CYCLES = 200,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] word0,
    input  logic        req1,
    input  logic [31:0] word1,
    output logic        ack0,
    output logic        ack1,
    output logic        busy,
    output logic        dds_load,
    output logic        dds_choice,
    output logic [15:0] dds_para,
    output logic        state_start,
    output logic        last_src,
    output logic [31:0] last_word
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_LO,
        S_LOAD_HI,
        S_START,
        S_WAIT,
        S_ACK,
        S_GAP
    } state_e;

    localparam logic [CNT_W-1:0] XferLoad = CNT_W'(XFER_CYCLES);
    localparam logic [CNT_W-1:0] GapLoad  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;
    logic             src_q, src_d;
    logic             grant;

    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        busy_q, busy_d;
    logic        load_q, load_d;
    logic        choice_q, choice_d;
    logic [15:0] para_q, para_d;
    logic        start_q, start_d;

    // Next-state logic; the granted word and source are captured only on the IDLE exit edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        src_d   = src_q;
        grant   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant   = (req0 && req1) ? ~src_q : req1;
                    src_d   = grant;
                    word_d  = grant ? word1 : word0;
                    state_d = S_LOAD_LO;
                end
            end
            S_LOAD_LO: state_d = S_LOAD_HI;
            S_LOAD_HI: state_d = S_START;
            S_START: begin
                cnt_d   = XferLoad;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q <= CntOne) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (GAP_CYCLES > 0) begin
                    cnt_d   = GapLoad;
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q <= CntOne) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state they belong to.
    always_comb begin
        ack0_d   = (state_d == S_ACK) && !src_d;
        ack1_d   = (state_d == S_ACK) && src_d;
        busy_d   = (state_d != S_IDLE);
        load_d   = (state_d == S_LOAD_LO) || (state_d == S_LOAD_HI);
        start_d  = (state_d == S_START);
        choice_d = choice_q;
        para_d   = para_q;
        if (state_d == S_LOAD_LO) begin
            choice_d = 1'b0;
            para_d   = word_d[15:0];
        end else if (state_d == S_LOAD_HI) begin
            choice_d = 1'b1;
            para_d   = word_d[31:16];
        end
    end

    // last_src resets to 1 so the first contested grant goes to the pulse sequencer.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            src_q    <= 1'b1;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
            load_q   <= 1'b0;
            choice_q <= 1'b0;
            para_q   <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            src_q    <= src_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
            load_q   <= load_d;
            choice_q <= choice_d;
            para_q   <= para_d;
            start_q  <= start_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign busy        = busy_q;
    assign dds_load    = load_q;
    assign dds_choice  = choice_q;
    assign dds_para    = para_q;
    assign state_start = start_q;
    assign last_src    = src_q;
    assign last_word   = word_q;

endmodule

// File: tb/tb_dds_prog_arb.sv
// Scoreboard bench for dds_prog_arb: directed transactions push timed expected events, a negedge monitor pops them.
// A second instance with XFER_CYCLES=1, GAP_CYCLES=0 covers the shortest sequence.
module tb_dds_prog_arb;

    typedef struct {
        int          dut;
        int          kind;
        logic [15:0] val;
        int          at;
    } ev_t;

    logic clk_sys;
    logic rst;

    logic        aReq0, aReq1, aAck0, aAck1, aBusy, aLoad, aChoice, aStart, aLastSrc;
    logic [31:0] aWord0, aWord1, aLastWord;
    logic [15:0] aPara;

    logic        bReq0, bReq1, bAck0, bAck1, bBusy, bLoad, bChoice, bStart, bLastSrc;
    logic [31:0] bWord0, bWord1, bLastWord;
    logic [15:0] bPara;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  c;
    ev_t expQ[$];

    dds_prog_arb dutA (
        .clk_sys(clk_sys), .rst(rst),
        .req0(aReq0), .word0(aWord0), .req1(aReq1), .word1(aWord1),
        .ack0(aAck0), .ack1(aAck1), .busy(aBusy),
        .dds_load(aLoad), .dds_choice(aChoice), .dds_para(aPara),
        .state_start(aStart), .last_src(aLastSrc), .last_word(aLastWord)
    );

    dds_prog_arb #(.XFER_CYCLES(1), .GAP_CYCLES(0)) dutB (
        .clk_sys(clk_sys), .rst(rst),
        .req0(bReq0), .word0(bWord0), .req1(bReq1), .word1(bWord1),
        .ack0(bAck0), .ack1(bAck1), .busy(bBusy),
        .dds_load(bLoad), .dds_choice(bChoice), .dds_para(bPara),
        .state_start(bStart), .last_src(bLastSrc), .last_word(bLastWord)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Event kinds: 0 load low half, 1 load high half, 2 start strobe, 3 ack0, 4 ack1.
    task automatic pushTxn(input int dut, input int src, input logic [31:0] word,
                           input int base, input int xfer, input bit withAck);
        expQ.push_back('{dut: dut, kind: 0, val: word[15:0], at: base + 1});
        expQ.push_back('{dut: dut, kind: 1, val: word[31:16], at: base + 2});
        expQ.push_back('{dut: dut, kind: 2, val: 16'h0, at: base + 3});
        if (withAck) begin
            expQ.push_back('{dut: dut, kind: 3 + src, val: 16'h0, at: base + 4 + xfer});
        end
    endtask

    task automatic checkEvent(input int dut, input int kind, input logic [15:0] val);
        ev_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: got dut=%0d kind=%0d val=%h at cyc %0d, required none",
                     dut, kind, val, cyc);
        end else begin
            e = expQ.pop_front();
            if (e.dut != dut || e.kind != kind || e.val != val || e.at != cyc) begin
                errors++;
                $display("[TB] FAIL event: got dut=%0d kind=%0d val=%h cyc=%0d, required dut=%0d kind=%0d val=%h cyc=%0d",
                         dut, kind, val, cyc, e.dut, e.kind, e.val, e.at);
            end
        end
    endtask

    always @(negedge clk_sys) begin
        if (aLoad)  checkEvent(0, aChoice ? 1 : 0, aPara);
        if (aStart) checkEvent(0, 2, 16'h0);
        if (aAck0)  checkEvent(0, 3, 16'h0);
        if (aAck1)  checkEvent(0, 4, 16'h0);
        if (bLoad)  checkEvent(1, bChoice ? 1 : 0, bPara);
        if (bStart) checkEvent(1, 2, 16'h0);
        if (bAck0)  checkEvent(1, 3, 16'h0);
        if (bAck1)  checkEvent(1, 4, 16'h0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [31:0] w0, input logic r1, input logic [31:0] w1);
        aReq0  = r0;
        aWord0 = w0;
        aReq1  = r1;
        aWord1 = w1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic waitIdleA(input int bound);
        int n;
        n = 0;
        while (aBusy && n < bound) begin
            @(negedge clk_sys);
            n++;
        end
        checkOutput("idle_timeout", {31'b0, aBusy}, 32'h0);
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "_outs"}, {10'b0, aAck0, aAck1, aBusy, aLoad, aChoice, aStart, aPara}, 32'h0);
        checkOutput({tag, "_last_src"}, {31'b0, aLastSrc}, 32'h1);
        checkOutput({tag, "_last_word"}, aLastWord, 32'h0);
    endtask

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        bReq0 = 1'b0; bWord0 = 32'h0; bReq1 = 1'b0; bWord1 = 32'h0;
        waitCycles(3);
        checkResetA("reset");
        rst = 1'b0;
        waitCycles(1);

        // Single request with default timing.
        c = cyc;
        applyStimulus(1'b1, 32'h12345678, 1'b0, 32'h0);
        pushTxn(0, 0, 32'h12345678, c, 200, 1);
        waitCycles(204);
        aReq0 = 1'b0;
        waitCycles(4);
        checkOutput("busy_last_gap", {31'b0, aBusy}, 32'h1);
        waitCycles(1);
        checkOutput("busy_idle_209", {31'b0, aBusy}, 32'h0);
        checkOutput("t1_last_src", {31'b0, aLastSrc}, 32'h0);
        checkOutput("t1_last_word", aLastWord, 32'h12345678);

        // Simultaneous requests right after reset: req0 first, req1 granted at cycle 209.
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        waitCycles(1);
        c = cyc;
        applyStimulus(1'b1, 32'h0BADF00D, 1'b1, 32'hA5A50F0F);
        pushTxn(0, 0, 32'h0BADF00D, c, 200, 1);
        pushTxn(0, 1, 32'hA5A50F0F, c + 209, 200, 1);
        waitCycles(204);
        aReq0 = 1'b0;
        waitCycles(209);
        aReq1 = 1'b0;
        checkOutput("t2_last_src", {31'b0, aLastSrc}, 32'h1);
        checkOutput("t2_last_word", aLastWord, 32'hA5A50F0F);
        waitIdleA(20);

        // Both held continuously: grants alternate 0,1,0,1.
        c = cyc;
        applyStimulus(1'b1, 32'h01020304, 1'b1, 32'hF0E0D0C0);
        for (int k = 0; k < 4; k++) begin
            pushTxn(0, k % 2, (k % 2) ? 32'hF0E0D0C0 : 32'h01020304, c + 209 * k, 200, 1);
        end
        waitCycles(209 * 3 + 204);
        applyStimulus(1'b0, 32'h01020304, 1'b0, 32'hF0E0D0C0);
        waitIdleA(20);

        // Reset during WAIT: outputs clear at once, no ack, req1 re-served afterwards.
        c = cyc;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h13579BDF);
        pushTxn(0, 1, 32'h13579BDF, c, 200, 0);
        waitCycles(103);
        rst = 1'b1;
        #1;
        checkResetA("midreset");
        waitCycles(1);
        rst = 1'b0;
        c = cyc;
        pushTxn(0, 1, 32'h13579BDF, c, 200, 1);
        waitCycles(204);
        aReq1 = 1'b0;
        waitIdleA(20);

        // Shortest instance: word change during LOAD ignored, back-to-back grant at cycle 6.
        c = cyc;
        bReq0 = 1'b1;
        bWord0 = 32'h11112222;
        pushTxn(1, 0, 32'h11112222, c, 1, 1);
        pushTxn(1, 0, 32'hFFFFFFFF, c + 6, 1, 1);
        waitCycles(1);
        bWord0 = 32'hFFFFFFFF;
        waitCycles(4);
        checkOutput("b_busy_ack", {31'b0, bBusy}, 32'h1);
        waitCycles(1);
        checkOutput("b_busy_idle6", {31'b0, bBusy}, 32'h0);
        waitCycles(5);
        bReq0 = 1'b0;
        waitCycles(2);
        checkOutput("b_no_repeat", {31'b0, bBusy}, 32'h0);
        checkOutput("b_last_word", bLastWord, 32'hFFFFFFFF);

        // Request dropped at cycle 2: the transfer still completes and acks.
        c = cyc;
        applyStimulus(1'b1, 32'hCAFEBABE, 1'b0, 32'h0);
        pushTxn(0, 0, 32'hCAFEBABE, c, 200, 1);
        waitCycles(2);
        aReq0 = 1'b0;
        waitCycles(202);
        waitIdleA(20);
        waitCycles(10);

        checkOutput("queue_empty", expQ.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_prog_arb.md
Name: dds_prog_arb

Overview:
- Arbitrates two requesters, the pulse sequencer and the host scan engine, for the single DDS programming path.
- Sequences each granted 32-bit tuning word into the DDS block: low half, then high half, then a start strobe.
- Waits a fixed serial-transfer time, then acknowledges the requester.
- Sits between the requesters and the DDS block's dds_load / dds_choice / dds_para / state_start inputs.

Parameters:
XFER_CYCLES, 200, cycles spent in WAIT after state_start (covers the DDS serial shift and fq_ud); legal range 1..65535
GAP_CYCLES, 4, idle guard cycles after each ack before the next grant; 0 skips GAP
CNT_W, 16, width of the shared WAIT/GAP down-counter

Ports:
clk_sys  in  1  system clock
rst  in  1  asynchronous reset, active-high
req0  in  1  requester 0 (pulse sequencer) request, level, held until ack0
word0  in  32  requester 0 tuning word
req1  in  1  requester 1 (host scan) request, level, held until ack1
word1  in  32  requester 1 tuning word
ack0  out  1  one-cycle completion pulse to requester 0
ack1  out  1  one-cycle completion pulse to requester 1
busy  out  1  high in every state except IDLE
dds_load  out  1  one-cycle load strobe to the DDS block
dds_choice  out  1  0 = low half, 1 = high half
dds_para  out  16  half-word presented to the DDS block
state_start  out  1  one-cycle start of serial transfer
last_src  out  1  source of the most recent grant
last_word  out  32  most recently granted word

Behaviour:
- Reset: clock and reset are as stated in Ports (clk_sys; rst asynchronous, active-high). While rst is high, all outputs are 0, state = IDLE, counter = 0, last_src = 1, last_word = 0.
- All outputs are registered and are a function of the current state only.
- States: IDLE, LOAD_LO, LOAD_HI, START, WAIT, ACK, GAP.
- IDLE:
  - At a clock edge with req0 or req1 high, grant one source.
  - Both high: grant ~last_src (round-robin). After reset this favours req0.
  - Only one high: grant it.
  - At the grant edge: capture word, last_word and last_src; go to LOAD_LO.
- LOAD_LO: dds_load = 1, dds_choice = 0, dds_para = word[15:0]; go to LOAD_HI.
- LOAD_HI: dds_load = 1, dds_choice = 1, dds_para = word[31:16]; go to START.
- START: state_start = 1; load counter with XFER_CYCLES; go to WAIT.
- WAIT: decrement each cycle; occupies exactly XFER_CYCLES cycles; go to ACK.
- ACK: ackN = 1 for the granted source only. Then:
  - GAP_CYCLES > 0: go to GAP.
  - GAP_CYCLES = 0: go to IDLE.
- GAP: occupies exactly GAP_CYCLES cycles; go to IDLE.
- Output holds and defaults:
  - dds_choice and dds_para hold their last values outside the LOAD states.
  - dds_load, state_start and ack* are 0 outside their states.
- Timing, with the grant edge as cycle 0:
  - dds_load high in cycles 1 and 2.
  - state_start high in cycle 3.
  - WAIT spans cycles 4..3+XFER_CYCLES.
  - ack in cycle 4+XFER_CYCLES.
  - GAP spans the next GAP_CYCLES cycles.
  - IDLE at cycle 5+XFER_CYCLES+GAP_CYCLES.
- Word capture: the word is sampled only at the grant edge. Changes to wordN during a transaction are ignored.
- Request dropped mid-transaction: the transaction completes and ack still pulses.
- Request still high after ack: a requester that keeps reqN high after its ack is treated as a new request at the next IDLE. A requester must drop req in the cycle after ack to avoid a repeat transfer.
- Reset mid-transaction: outputs go to 0 immediately and no ack is issued. The requester keeps req high and is re-served after reset release.
- Request timing: a new request arriving during any non-IDLE state waits. No request is lost while its req level is held.

Test Plan:
- Single request (defaults): req0 = 1, word0 = 0x12345678 → dds_para 0x5678 with choice 0 at cycle 1, 0x1234 with choice 1 at cycle 2; state_start at cycle 3; ack0 at cycle 204; busy low from cycle 209.
- Simultaneous requests after reset: req0 and req1 high together, word1 = 0xA5A5_0F0F → req0 served first (ack0 at 204); req1 granted at cycle 209; ack1 at cycle 413; last_src = 1; last_word = 0xA5A50F0F.
- Both requests held continuously: grants alternate 0,1,0,1; no source is granted twice in a row; each ack lands on the matching ack line.
- Reset mid-transaction: assert rst at WAIT cycle 100 → all outputs 0 at once; no ack. Release with req1 still high → fresh sequence for req1, dds_load at cycles 1 and 2 after the grant.
- GAP_CYCLES = 0, XFER_CYCLES = 1: ack at cycle 5; next grant possible at cycle 6; req changes on word0 during the LOAD states have no effect on dds_para.
- Request dropped mid-transaction: req0 deasserted at cycle 2 → the sequence still completes and ack0 pulses at cycle 204.
